// File: rtl/bp_cfg_loader_pkg.sv
// bp_cfg_loader_pkg
//   Shared definitions for the boot-time cfg loader: cfg register addresses,
//   the CCE mode encoding, the loader FSM state encoding and a width helper
//   that never returns 0 (so single-core / single-entry builds stay legal).
package bp_cfg_loader_pkg;

    localparam logic [15:0] freeze_addr     = 16'h0002;
    localparam logic [15:0] cce_mode_addr   = 16'h0004;
    localparam logic [15:0] ucode_base_addr = 16'h8000;

    typedef enum logic [0:0] {
        e_cce_mode_uncached = 1'b0,
        e_cce_mode_normal   = 1'b1
    } bp_cce_mode_e;

    typedef enum logic [2:0] {
        e_idle,
        e_freeze,
        e_fetch,
        e_wait,
        e_ucode,
        e_mode,
        e_unfreeze,
        e_done
    } bp_cfg_state_e;

    // Counter width that is at least 1 bit even for a count of 1.
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bp_cfg_loader_ucode_fetch.sv
// bp_cfg_loader_ucode_fetch
//   Microcode ROM reader for the cfg loader. Owns the entry index, the ROM
//   read strobe and the one-entry holding register.
//   Ports:
//     clk_i, reset_n_i  clock, async active-low reset
//     clear_i           restart the entry index at 0
//     fetch_i           issue a ROM read at the current index this cycle
//     yumi_i            held entry consumed; advance index unless last
//     ucode_v_o/addr_o  ROM read strobe and index
//     ucode_data_i      ROM data, valid the cycle after the strobe
//     v_o, data_o       holding register valid and contents
//     cnt_o, last_o     current index and "index is the final entry"
module bp_cfg_loader_ucode_fetch
    import bp_cfg_loader_pkg::*;
#(
    parameter  int unsigned num_cce_instr_ram_els = 256,
    parameter  int unsigned cfg_data_width        = 32,
    localparam int unsigned cnt_width             = safe_clog2(num_cce_instr_ram_els)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      clear_i,
    input  logic                      fetch_i,
    input  logic                      yumi_i,
    output logic                      ucode_v_o,
    output logic [cnt_width-1:0]      ucode_addr_o,
    input  logic [cfg_data_width-1:0] ucode_data_i,
    output logic                      v_o,
    output logic [cfg_data_width-1:0] data_o,
    output logic [cnt_width-1:0]      cnt_o,
    output logic                      last_o
);

    localparam logic [cnt_width-1:0] last_idx = cnt_width'(num_cce_instr_ram_els - 1);

    logic                      pend_q;
    logic                      v_q,    v_d;
    logic [cfg_data_width-1:0] data_q, data_d;
    logic [cnt_width-1:0]      cnt_q,  cnt_d;

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        // ROM data is only looked at in the cycle right after the strobe.
        if (pend_q) begin
            data_d = ucode_data_i;
            v_d    = 1'b1;
        end else if (yumi_i) begin
            v_d    = 1'b0;
        end
        if (clear_i) begin
            cnt_d = '0;
        end else if (yumi_i && !last_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pend_q <= 1'b0;
            v_q    <= 1'b0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= fetch_i;
            v_q    <= v_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ucode_v_o    = fetch_i;
    assign ucode_addr_o = cnt_q;
    assign v_o          = v_q;
    assign data_o       = data_q;
    assign cnt_o        = cnt_q;
    assign last_o       = (cnt_q == last_idx);

endmodule

// File: rtl/bp_cfg_loader.sv
// bp_cfg_loader
//   Boot-time cfg sequencer: for each core, freeze it, stream the CCE
//   microcode into its instruction RAM and set CCE mode to normal; then
//   unfreeze every core in order.
//   Ports:
//     clk_i, reset_n_i     clock, async active-low reset
//     start_i              pulse to begin a load (ignored while busy)
//     ucode_v_o/addr_o     microcode ROM read strobe / index
//     ucode_data_i         ROM data, one cycle after the strobe
//     cfg_v_o/ready_i      cfg write valid/ready handshake
//     cfg_core/addr/data_o cfg write target core, address and data
//     busy_o, done_o       sequence running / finished (sticky until start)
module bp_cfg_loader
    import bp_cfg_loader_pkg::*;
#(
    parameter  int unsigned num_core              = 1,
    parameter  int unsigned num_cce_instr_ram_els = 256,
    parameter  int unsigned cfg_core_width        = 8,
    parameter  int unsigned cfg_addr_width        = 16,
    parameter  int unsigned cfg_data_width        = 32,
    localparam int unsigned ucode_cnt_width       = safe_clog2(num_cce_instr_ram_els),
    localparam int unsigned core_cnt_width        = safe_clog2(num_core)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       start_i,
    output logic                       ucode_v_o,
    output logic [ucode_cnt_width-1:0] ucode_addr_o,
    input  logic [cfg_data_width-1:0]  ucode_data_i,
    output logic                       cfg_v_o,
    input  logic                       cfg_ready_i,
    output logic [cfg_core_width-1:0]  cfg_core_o,
    output logic [cfg_addr_width-1:0]  cfg_addr_o,
    output logic [cfg_data_width-1:0]  cfg_data_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam logic [core_cnt_width-1:0] core_last_idx = core_cnt_width'(num_core - 1);

    bp_cfg_state_e               state_q, state_d;
    logic [core_cnt_width-1:0]   core_cnt_q, core_cnt_d;
    logic                        done_q, done_d;

    logic                        xfer;
    logic                        uc_clear, uc_fetch, uc_yumi, uc_v, uc_last;
    logic [cfg_data_width-1:0]   uc_data;
    logic [ucode_cnt_width-1:0]  uc_cnt;

    bp_cfg_loader_ucode_fetch #(
        .num_cce_instr_ram_els(num_cce_instr_ram_els),
        .cfg_data_width       (cfg_data_width)
    ) u_fetch (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .clear_i     (uc_clear),
        .fetch_i     (uc_fetch),
        .yumi_i      (uc_yumi),
        .ucode_v_o   (ucode_v_o),
        .ucode_addr_o(ucode_addr_o),
        .ucode_data_i(ucode_data_i),
        .v_o         (uc_v),
        .data_o      (uc_data),
        .cnt_o       (uc_cnt),
        .last_o      (uc_last)
    );

    assign xfer = cfg_v_o && cfg_ready_i;

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_idle;
            core_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            core_cnt_q <= core_cnt_d;
            done_q     <= done_d;
        end
    end

    // Next state
    always_comb begin
        state_d    = state_q;
        core_cnt_d = core_cnt_q;
        done_d     = done_q;
        unique case (state_q)
            e_idle: if (start_i) begin
                state_d    = e_freeze;
                core_cnt_d = '0;
                done_d     = 1'b0;
            end
            e_freeze: if (xfer) state_d = e_fetch;
            e_fetch:  state_d = e_wait;
            e_wait:   state_d = e_ucode;
            e_ucode:  if (xfer) state_d = uc_last ? e_mode : e_fetch;
            e_mode: if (xfer) begin
                if (core_cnt_q == core_last_idx) begin
                    state_d    = e_unfreeze;
                    core_cnt_d = '0;
                end else begin
                    state_d    = e_freeze;
                    core_cnt_d = core_cnt_q + 1'b1;
                end
            end
            e_unfreeze: if (xfer) begin
                if (core_cnt_q == core_last_idx) state_d = e_done;
                else                             core_cnt_d = core_cnt_q + 1'b1;
            end
            e_done: begin
                done_d  = 1'b1;
                state_d = e_idle;
            end
            default: state_d = e_idle;
        endcase
    end

    // Outputs: cfg fields depend only on registered state, so they cannot
    // move while a write is stalled.
    always_comb begin
        cfg_v_o    = 1'b0;
        cfg_core_o = cfg_core_width'(core_cnt_q);
        cfg_addr_o = '0;
        cfg_data_o = '0;
        uc_fetch   = 1'b0;
        uc_clear   = 1'b0;
        uc_yumi    = 1'b0;
        busy_o     = 1'b1;
        done_o     = done_q;
        unique case (state_q)
            e_idle: busy_o = 1'b0;
            e_freeze: begin
                cfg_v_o    = 1'b1;
                cfg_addr_o = cfg_addr_width'(freeze_addr);
                cfg_data_o = cfg_data_width'(1);
                uc_clear   = xfer;
            end
            e_fetch: uc_fetch = 1'b1;
            e_wait:  ;
            e_ucode: begin
                cfg_v_o    = uc_v;
                cfg_addr_o = cfg_addr_width'(ucode_base_addr) + cfg_addr_width'(uc_cnt);
                cfg_data_o = uc_data;
                uc_yumi    = xfer;
            end
            e_mode: begin
                cfg_v_o    = 1'b1;
                cfg_addr_o = cfg_addr_width'(cce_mode_addr);
                cfg_data_o = cfg_data_width'(e_cce_mode_normal);
            end
            e_unfreeze: begin
                cfg_v_o    = 1'b1;
                cfg_addr_o = cfg_addr_width'(freeze_addr);
            end
            e_done: begin
                busy_o = 1'b0;
                done_o = 1'b1;
            end
            default: busy_o = 1'b0;
        endcase
    end

endmodule
